// File: rtl/ps2_key_fifo_if.sv
// ----------------------------------------------------------------------------
// ps2_key_fifo_if
//   Bundles the PS/2 pin inputs, the consumer pop request and the FIFO status
//   outputs of ps2_key_fifo.
//   master : drives ps2_clk, ps2_dat and rd_en. Observes the FIFO outputs.
//   slave  : the ps2_key_fifo side. Receives the pins and rd_en, and drives
//            ascii, valid, count, overflow and frame_err.
//   FIFO_DEPTH must match the FIFO_DEPTH of the connected ps2_key_fifo.
// ----------------------------------------------------------------------------
interface ps2_key_fifo_if #(
  parameter int FIFO_DEPTH = 8
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic          ps2_clk;    // raw PS/2 clock pin
  logic          ps2_dat;    // raw PS/2 data pin
  logic          rd_en;      // pop request
  logic [7:0]    ascii;      // head entry, 0x00 when empty
  logic          valid;      // FIFO non-empty
  logic [CW-1:0] count;      // occupancy
  logic          overflow;   // sticky key-dropped flag
  logic          frame_err;  // one-cycle frame error / timeout pulse

  modport master (
    output ps2_clk, ps2_dat, rd_en,
    input  ascii, valid, count, overflow, frame_err
  );

  modport slave (
    input  ps2_clk, ps2_dat, rd_en,
    output ascii, valid, count, overflow, frame_err
  );
endinterface

// File: rtl/ps2_key_fifo.sv
// ----------------------------------------------------------------------------
// ps2_key_fifo
//   PS/2 keyboard receiver. Frames are sampled from the raw pins, set-2 make
//   codes for A-Z, 0-9 and space are translated to ASCII and queued in a
//   show-ahead FIFO for the game core. Break (F0) and extended (E0) sequences
//   are swallowed.
//   clk, rst : system clock, asynchronous active-high reset
//   bus      : ps2_key_fifo_if.slave
//              in  ps2_clk, ps2_dat (asynchronous pins), rd_en
//              out ascii, valid, count, overflow, frame_err
// ----------------------------------------------------------------------------
module ps2_key_fifo #(
  parameter int FIFO_DEPTH     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic          clk,
  input  logic          rst,
  ps2_key_fifo_if.slave bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_e;

  // Set-2 make code to {hit, ascii}. A miss means the key is not queued.
  function automatic logic [8:0] xlate(input logic [7:0] code);
    case (code)
      8'h1C: return {1'b1, 8'h41};  8'h32: return {1'b1, 8'h42};
      8'h21: return {1'b1, 8'h43};  8'h23: return {1'b1, 8'h44};
      8'h24: return {1'b1, 8'h45};  8'h2B: return {1'b1, 8'h46};
      8'h34: return {1'b1, 8'h47};  8'h33: return {1'b1, 8'h48};
      8'h43: return {1'b1, 8'h49};  8'h3B: return {1'b1, 8'h4A};
      8'h42: return {1'b1, 8'h4B};  8'h4B: return {1'b1, 8'h4C};
      8'h3A: return {1'b1, 8'h4D};  8'h31: return {1'b1, 8'h4E};
      8'h44: return {1'b1, 8'h4F};  8'h4D: return {1'b1, 8'h50};
      8'h15: return {1'b1, 8'h51};  8'h2D: return {1'b1, 8'h52};
      8'h1B: return {1'b1, 8'h53};  8'h2C: return {1'b1, 8'h54};
      8'h3C: return {1'b1, 8'h55};  8'h2A: return {1'b1, 8'h56};
      8'h1D: return {1'b1, 8'h57};  8'h22: return {1'b1, 8'h58};
      8'h35: return {1'b1, 8'h59};  8'h1A: return {1'b1, 8'h5A};
      8'h45: return {1'b1, 8'h30};  8'h16: return {1'b1, 8'h31};
      8'h1E: return {1'b1, 8'h32};  8'h26: return {1'b1, 8'h33};
      8'h25: return {1'b1, 8'h34};  8'h2E: return {1'b1, 8'h35};
      8'h36: return {1'b1, 8'h36};  8'h3D: return {1'b1, 8'h37};
      8'h3E: return {1'b1, 8'h38};  8'h46: return {1'b1, 8'h39};
      8'h29: return {1'b1, 8'h20};
      default: return 9'h000;
    endcase
  endfunction

  // Pin synchronizers and falling-edge history.
  logic clk_s1_q, clk_s2_q, clk_prev_q, dat_s1_q, dat_s2_q;
  logic clk_s1_d, clk_s2_d, clk_prev_d, dat_s1_d, dat_s2_d;

  state_e        state_q, state_d;
  logic [7:0]    shift_q, shift_d;
  logic [2:0]    bitcnt_q, bitcnt_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          brk_q, brk_d, ext_q, ext_d;
  logic          push_q, push_d;
  logic [7:0]    push_data_q, push_data_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;
  logic [7:0]    mem_q [FIFO_DEPTH];

  logic fall, dat, timeout, frame_err, byte_done, pop, full, wr;

  always_comb begin
    clk_s1_d   = bus.ps2_clk;
    clk_s2_d   = clk_s1_q;
    clk_prev_d = clk_s2_q;
    dat_s1_d   = bus.ps2_dat;
    dat_s2_d   = dat_s1_q;
  end

  assign fall = clk_prev_q & ~clk_s2_q;
  assign dat  = dat_s2_q;
  // An edge in the same cycle restarts the count rather than timing out.
  assign timeout = (state_q != S_IDLE) && !fall && (tmo_q == TW'(TIMEOUT_CYCLES - 1));

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // FSM next state plus shift register, bit counter and timeout counter.
  always_comb begin
    // NOTE: every signal assigned in this block gets a default first, so no
    // path leaves a value unassigned and no latch is inferred.
    state_d  = state_q;
    shift_d  = shift_q;
    bitcnt_d = bitcnt_q;
    if (state_q == S_IDLE || fall) tmo_d = '0;
    else                           tmo_d = tmo_q + TW'(1);
    if (fall) begin
      case (state_q)
        S_IDLE: if (!dat) begin
          shift_d  = '0;
          bitcnt_d = '0;
          state_d  = S_DATA;
        end
        S_DATA: begin
          shift_d  = {dat, shift_q[7:1]};
          bitcnt_d = bitcnt_q + 3'd1;
          if (bitcnt_q == 3'd7) state_d = S_PARITY;
        end
        S_PARITY: state_d = (^{shift_q, dat}) ? S_STOP : S_IDLE;
        default:  state_d = S_IDLE;
      endcase
    end
    if (timeout) state_d = S_IDLE;
  end

  // FSM outputs.
  always_comb begin
    frame_err = 1'b0;
    byte_done = 1'b0;
    if (fall) begin
      case (state_q)
        S_IDLE:   frame_err = dat;
        S_PARITY: frame_err = ~(^{shift_q, dat});
        S_STOP: begin
          frame_err = ~dat;
          byte_done = dat;
        end
        default: ;
      endcase
    end
    if (timeout) frame_err = 1'b1;
  end

  // Byte decode: prefix flags and registered translation.
  always_comb begin
    brk_d       = brk_q;
    ext_d       = ext_q;
    push_d      = 1'b0;
    push_data_d = push_data_q;
    if (byte_done) begin
      if (shift_q == 8'hF0)      brk_d = 1'b1;
      else if (shift_q == 8'hE0) ext_d = 1'b1;
      else if (brk_q || ext_q) begin
        brk_d = 1'b0;
        ext_d = 1'b0;
      end else {push_d, push_data_d} = xlate(shift_q);
    end
  end

  // FIFO control. A push into a full FIFO is accepted only alongside a pop.
  always_comb begin
    pop        = bus.rd_en && (count_q != '0);
    full       = (count_q == CW'(FIFO_DEPTH));
    wr         = push_q && (!full || pop);
    overflow_d = overflow_q | (push_q & full & ~pop);
    wr_ptr_d   = wr  ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d   = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d    = count_q;
    if (wr && !pop)      count_d = count_q + CW'(1);
    else if (!wr && pop) count_d = count_q - CW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of the others regardless of statement order.
    if (rst) begin
      clk_s1_q    <= 1'b1;  // idle-high so reset release cannot fake an edge
      clk_s2_q    <= 1'b1;
      clk_prev_q  <= 1'b1;
      dat_s1_q    <= 1'b1;
      dat_s2_q    <= 1'b1;
      shift_q     <= '0;
      bitcnt_q    <= '0;
      tmo_q       <= '0;
      brk_q       <= 1'b0;
      ext_q       <= 1'b0;
      push_q      <= 1'b0;
      push_data_q <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
    end else begin
      clk_s1_q    <= clk_s1_d;
      clk_s2_q    <= clk_s2_d;
      clk_prev_q  <= clk_prev_d;
      dat_s1_q    <= dat_s1_d;
      dat_s2_q    <= dat_s2_d;
      shift_q     <= shift_d;
      bitcnt_q    <= bitcnt_d;
      tmo_q       <= tmo_d;
      brk_q       <= brk_d;
      ext_q       <= ext_d;
      push_q      <= push_d;
      push_data_q <= push_data_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
    end
  end

  // NOTE: the storage array has no reset; count and the pointers decide which
  // entries are live, and ascii is forced to 0 while empty.
  always_ff @(posedge clk) begin
    if (wr) mem_q[wr_ptr_q] <= push_data_q;
  end

  assign bus.valid     = (count_q != '0);
  assign bus.ascii     = bus.valid ? mem_q[rd_ptr_q] : 8'h00;
  assign bus.count     = count_q;
  assign bus.overflow  = overflow_q;
  assign bus.frame_err = frame_err;
endmodule

// File: tb/tb_ps2_key_fifo.sv
// ----------------------------------------------------------------------------
// tb_ps2_key_fifo
//   Directed bench for ps2_key_fifo: drives PS/2 frames on the pins, checks a
//   table of single-frame vectors, then hand-written sequences for latency,
//   prefix handling, overflow, simultaneous push/pop, reset and timeout.
// ----------------------------------------------------------------------------
module tb_ps2_key_fifo;
  localparam int DEPTH = 8;
  localparam int TMO   = 50000;
  localparam int HALF  = 8;   // clk cycles per PS/2 clock half period

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ps2_key_fifo_if #(.FIFO_DEPTH(DEPTH)) bus ();

  ps2_key_fifo #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_vec  = 0;
  int n_fail = 0;

  // frame_err pulse monitor: counts pulses and pulses wider than one cycle.
  int err_cnt  = 0;
  int wide_err = 0;
  int err_run  = 0;
  always @(negedge clk) begin
    if (bus.frame_err) begin
      err_cnt++;
      err_run++;
      if (err_run == 2) wide_err++;
    end else begin
      err_run = 0;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // One PS/2 bit: data set while the clock is high, then a falling edge.
  task automatic ps2_bit(input logic b);
    bus.ps2_dat = b;
    repeat (HALF) @(negedge clk);
    bus.ps2_clk = 1'b0;
    repeat (HALF) @(negedge clk);
    bus.ps2_clk = 1'b1;
  endtask

  // Full frame. pop_at_push raises rd_en in the cycle the decoded key is
  // pushed; chk_lat checks valid rises exactly two cycles after the internal
  // stop-bit edge (pin edge + 2 synchronizer flops).
  task automatic send_frame(input logic [7:0] code, input bit bad_par, input bit bad_stop,
                            input bit pop_at_push, input bit chk_lat);
    logic par;
    par = ~(^code) ^ bad_par;
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(code[i]);
    ps2_bit(par);
    bus.ps2_dat = ~bad_stop;
    repeat (HALF) @(negedge clk);
    bus.ps2_clk = 1'b0;
    for (int i = 1; i <= HALF; i++) begin
      @(negedge clk);
      if (pop_at_push) bus.rd_en = (i == 3);
      if (chk_lat && i == 3) check("latency_valid_n+1", {31'd0, bus.valid}, 32'd0);
      if (chk_lat && i == 4) check("latency_valid_n+2", {31'd0, bus.valid}, 32'd1);
    end
    bus.ps2_clk = 1'b1;
  endtask

  task automatic pop_one();
    bus.rd_en = 1'b1;
    @(negedge clk);
    bus.rd_en = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  typedef struct {
    logic [7:0] code;
    bit         bad_par;
    bit         bad_stop;
    bit         pop_after;
    int         exp_count;
    logic [7:0] exp_ascii;
    int         exp_errs;
  } vec_t;

  vec_t vecs [9];

  initial begin
    int e0;
    int cycles;
    bit got;

    // A bad-parity frame also leaves its stop bit (1) arriving in IDLE,
    // which is itself a frame error: two pulses.
    vecs[0] = '{8'h24, 1'b1, 1'b0, 1'b0, 0, 8'h00, 2};
    vecs[1] = '{8'h24, 1'b0, 1'b1, 1'b0, 0, 8'h00, 1};
    vecs[2] = '{8'h29, 1'b0, 1'b0, 1'b0, 1, 8'h20, 0};
    vecs[3] = '{8'h45, 1'b0, 1'b0, 1'b0, 2, 8'h20, 0};
    vecs[4] = '{8'hF0, 1'b0, 1'b0, 1'b0, 2, 8'h20, 0};
    vecs[5] = '{8'h45, 1'b0, 1'b0, 1'b0, 2, 8'h20, 0};  // release: dropped
    vecs[6] = '{8'h5A, 1'b0, 1'b0, 1'b0, 2, 8'h20, 0};  // unmapped: dropped
    vecs[7] = '{8'h4D, 1'b0, 1'b0, 1'b0, 3, 8'h20, 0};
    vecs[8] = '{8'h1A, 1'b0, 1'b0, 1'b1, 4, 8'h20, 0};

    bus.ps2_clk = 1'b1;
    bus.ps2_dat = 1'b1;
    bus.rd_en   = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ascii",     {24'd0, bus.ascii},    32'h00);
    check("rst_valid",     {31'd0, bus.valid},    32'd0);
    check("rst_count",     {28'd0, bus.count},    32'd0);
    check("rst_overflow",  {31'd0, bus.overflow}, 32'd0);
    check("rst_frame_err", {31'd0, bus.frame_err}, 32'd0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // First frame: 0x1C -> 'A' with precise latency, then pop to empty.
    send_frame(8'h1C, 1'b0, 1'b0, 1'b0, 1'b1);
    check("a_ascii", {24'd0, bus.ascii}, 32'h41);
    check("a_count", {28'd0, bus.count}, 32'd1);
    pop_one();
    check("a_pop_valid", {31'd0, bus.valid}, 32'd0);
    check("a_pop_ascii", {24'd0, bus.ascii}, 32'h00);

    // Table-driven single-frame vectors.
    for (int i = 0; i < 9; i++) begin
      e0 = err_cnt;
      send_frame(vecs[i].code, vecs[i].bad_par, vecs[i].bad_stop, 1'b0, 1'b0);
      check($sformatf("vec%0d_count", i), {28'd0, bus.count}, vecs[i].exp_count);
      check($sformatf("vec%0d_ascii", i), {24'd0, bus.ascii}, {24'd0, vecs[i].exp_ascii});
      check($sformatf("vec%0d_errs", i), err_cnt - e0, vecs[i].exp_errs);
      if (vecs[i].pop_after) pop_one();
    end
    check("tbl_head1", {24'd0, bus.ascii}, 32'h30); pop_one();
    check("tbl_head2", {24'd0, bus.ascii}, 32'h50); pop_one();
    check("tbl_head3", {24'd0, bus.ascii}, 32'h5A); pop_one();
    check("tbl_empty", {28'd0, bus.count}, 32'd0);
    pop_one();  // rd_en while empty is ignored
    check("empty_pop_count", {28'd0, bus.count}, 32'd0);
    check("empty_pop_valid", {31'd0, bus.valid}, 32'd0);

    // Prefix sequence: 1C F0 1C E0 75 16 -> 'A','1'.
    send_frame(8'h1C, 1'b0, 1'b0, 1'b0, 1'b0);
    send_frame(8'hF0, 1'b0, 1'b0, 1'b0, 1'b0);
    send_frame(8'h1C, 1'b0, 1'b0, 1'b0, 1'b0);
    send_frame(8'hE0, 1'b0, 1'b0, 1'b0, 1'b0);
    send_frame(8'h75, 1'b0, 1'b0, 1'b0, 1'b0);
    send_frame(8'h16, 1'b0, 1'b0, 1'b0, 1'b0);
    check("seq_count", {28'd0, bus.count}, 32'd2);
    check("seq_head0", {24'd0, bus.ascii}, 32'h41); pop_one();
    check("seq_head1", {24'd0, bus.ascii}, 32'h31); pop_one();
    check("seq_empty", {31'd0, bus.valid}, 32'd0);

    // Overflow: nine 'Q' with no reads.
    do_reset();
    for (int i = 0; i < 9; i++) send_frame(8'h15, 1'b0, 1'b0, 1'b0, 1'b0);
    check("ovf_count", {28'd0, bus.count}, 32'd8);
    check("ovf_flag", {31'd0, bus.overflow}, 32'd1);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("ovf_pop%0d", i), {24'd0, bus.ascii}, 32'h51);
      pop_one();
    end
    check("ovf_drained", {28'd0, bus.count}, 32'd0);

    // Reset mid-frame with three entries queued.
    send_frame(8'h1C, 1'b0, 1'b0, 1'b0, 1'b0);
    send_frame(8'h32, 1'b0, 1'b0, 1'b0, 1'b0);
    send_frame(8'h21, 1'b0, 1'b0, 1'b0, 1'b0);
    check("mid_count", {28'd0, bus.count}, 32'd3);
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("mid_rst_ascii",    {24'd0, bus.ascii},     32'h00);
    check("mid_rst_valid",    {31'd0, bus.valid},     32'd0);
    check("mid_rst_count",    {28'd0, bus.count},     32'd0);
    check("mid_rst_overflow", {31'd0, bus.overflow},  32'd0);
    check("mid_rst_ferr",     {31'd0, bus.frame_err}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    send_frame(8'h29, 1'b0, 1'b0, 1'b0, 1'b0);
    check("post_rst_ascii", {24'd0, bus.ascii}, 32'h20);
    check("post_rst_count", {28'd0, bus.count}, 32'd1);

    // Full FIFO: push of 'B' coincides with a pop.
    do_reset();
    for (int i = 0; i < 8; i++) send_frame(8'h15, 1'b0, 1'b0, 1'b0, 1'b0);
    check("full_count", {28'd0, bus.count}, 32'd8);
    send_frame(8'h32, 1'b0, 1'b0, 1'b1, 1'b0);
    check("pp_count", {28'd0, bus.count}, 32'd8);
    check("pp_overflow", {31'd0, bus.overflow}, 32'd0);
    for (int i = 0; i < 7; i++) begin
      check($sformatf("pp_pop%0d", i), {24'd0, bus.ascii}, 32'h51);
      pop_one();
    end
    check("pp_tail", {24'd0, bus.ascii}, 32'h42);
    pop_one();
    check("pp_empty", {28'd0, bus.count}, 32'd0);

    // Timeout: start bit plus three data bits, then silence.
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    ps2_bit(1'b0);
    bus.ps2_dat = 1'b1;
    repeat (HALF) @(negedge clk);
    bus.ps2_clk = 1'b0;
    cycles = 0;
    got = 1'b0;
    while (!got && cycles < TMO + 100) begin
      @(negedge clk);
      cycles++;
      if (cycles == HALF) bus.ps2_clk = 1'b1;
      if (bus.frame_err) got = 1'b1;
    end
    check("tmo_seen", {31'd0, got}, 32'd1);
    n_vec++;
    if (cycles < TMO + 1 || cycles > TMO + 4) begin
      n_fail++;
      $display("FAIL tmo_latency: got %0d cycles, expected %0d..%0d", cycles, TMO + 1, TMO + 4);
    end
    repeat (4) @(negedge clk);
    e0 = err_cnt;
    send_frame(8'h45, 1'b0, 1'b0, 1'b0, 1'b0);
    check("tmo_next_ascii", {24'd0, bus.ascii}, 32'h30);
    check("tmo_next_count", {28'd0, bus.count}, 32'd1);
    check("tmo_next_errs", err_cnt - e0, 32'd0);

    check("ferr_width", wide_err, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule

// File: doc/ps2_key_fifo.md
Name: ps2_key_fifo

Overview:
- Receives PS/2 keyboard frames from the board PS/2 pins.
- Decodes set-2 make codes for letters, digits and space into ASCII, and queues them in a small show-ahead FIFO.
- The game core pops the FIFO to compare each typed key against the falling characters.
- This is the player-input side of the game, opposite the character generator / VGA display path.

Parameters:
- FIFO_DEPTH, 8, number of queued ASCII entries; must be a power of 2, minimum 2.
- TIMEOUT_CYCLES, 50000, clk cycles with no PS/2 falling edge before a partial frame is abandoned (1 ms at 50 MHz).

Ports:
- clk  in  1  system clock, CLOCK_50 domain.
- rst  in  1  asynchronous reset, active-high.
- ps2_clk  in  1  raw PS/2 clock from the pin, asynchronous to clk.
- ps2_dat  in  1  raw PS/2 data from the pin, asynchronous to clk.
- rd_en  in  1  consumer pop request; honoured only when valid=1.
- ascii  out  8  ASCII code at the FIFO head; 0x00 when empty.
- valid  out  1  FIFO non-empty.
- count  out  $clog2(FIFO_DEPTH)+1  current occupancy.
- overflow  out  1  sticky; set when a key is dropped because the FIFO is full.
- frame_err  out  1  one-cycle pulse on a start, parity or stop error, or on timeout.

Behaviour:

Reset and input sampling
- Reset (async, rst=1): ascii=0, valid=0, count=0, overflow=0, frame_err=0; FSM goes to IDLE; break/ext flags clear; FIFO empty.
- Reset asserted mid-frame discards the partial frame and the FIFO contents.
- ps2_clk and ps2_dat each pass through a 2-FF synchronizer.
- A falling edge is detected when the previous synced clk=1 and the current synced clk=0. The synced data bit is sampled in that same cycle.

Frame FSM
- IDLE: on an edge with data=0 (start bit), clear the shift register and go to DATA with bitcnt=0. An edge with data=1 stays in IDLE and raises frame_err.
- DATA: shift in 8 bits, LSB first, one per edge. After the 8th bit go to PARITY.
- PARITY: the sampled bit must make data+parity odd. On failure, pulse frame_err, go to IDLE, discard.
- STOP: the sampled bit must be 1; otherwise pulse frame_err and discard. Either way return to IDLE. A good stop bit asserts byte_done for 1 cycle (internal).
- Timeout: in any state other than IDLE, a cycle counter resets on every edge. When it reaches TIMEOUT_CYCLES, pulse frame_err, go to IDLE and discard. The counter is held at 0 in IDLE.

Byte decode (on byte_done)
- 0xF0: set break flag.
- 0xE0: set ext flag.
- Any other byte with break or ext set: discard it and clear both flags (release and extended keys are never queued).
- Otherwise translate:
  - Letters A–Z → 0x41–0x5A: A1C B32 C21 D23 E24 F2B G34 H33 I43 J3B K42 L4B M3A N31 O44 P4D Q15 R2D S1B T2C U3C V2A W1D X22 Y35 Z1A.
  - Digits 0–9 → 0x30–0x39: 0:45 1:16 2:1E 3:26 4:25 5:2E 6:36 7:3D 8:3E 9:46.
  - 0x29 → 0x20 (space).
  - Any other code is dropped silently.
- Translation is registered.
- Latency: byte_done in cycle N gives push in N+1, with valid/ascii/count updated in N+2.

FIFO
- Show-ahead: ascii always reflects the head entry.
- Pop when rd_en=1 and valid=1. rd_en while empty is ignored, with no state change.
- Push and pop in the same cycle: both occur and count is unchanged. This holds when full as well, with no overflow.
- Push while full without a pop: the new key is dropped and overflow sets. overflow clears only on rst.
- Pointers wrap modulo FIFO_DEPTH.
- count saturates at FIFO_DEPTH and never underflows.

Test Plan:
- Frame 0x1C with odd parity bit 0, stop 1 → valid=1 two cycles after the stop edge, ascii=0x41, count=1. rd_en for 1 cycle → valid=0, ascii=0x00.
- Sequence 1C, F0, 1C, E0, 75, 16 → FIFO holds 0x41 then 0x31 only; count=2.
- Frame 0x24 with a wrong parity bit → frame_err pulses exactly 1 cycle, nothing queued. Frame 0x24 with stop=0 → same result.
- 9 make codes (0x15 ×9) with no reads, FIFO_DEPTH=8 → count=8, overflow=1, eight 0x51 popped. Then, when full, push and rd_en in the same cycle → count stays 8 and overflow does not re-trigger.
- Start bit plus 3 data bits, then idle for 50000 cycles → frame_err pulse at the timeout. A following valid frame 0x45 is queued as 0x30.
- rst asserted mid-frame and with 3 entries queued → all outputs 0 at once. The next full frame 0x29 yields ascii=0x20.
